// File: rtl/mem_interface_unit.sv
// Memory-side bus consumer: holds MAR/MDR and runs single-word RAM reads/writes
// over a req/ack handshake, aborting with a sticky error after TIMEOUT wait cycles.
module mem_interface_unit #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic              Read,
   input  logic              Write,
   output logic [DATA_W-1:0] MDRdataOut,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FINISH} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
            if (MDRin) mdr_d = BusMuxOut;
            // Read has priority; a simultaneous Write is simply dropped
            if (Read) begin
               state_d = RD_WAIT;
               req_d   = 1'b1;
               we_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end else if (Write) begin
               state_d = WR_WAIT;
               req_d   = 1'b1;
               we_d    = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         RD_WAIT, WR_WAIT: begin
            // ack on the expiry cycle still wins over the timeout
            if (mem_ack) begin
               if (state_q == RD_WAIT) mdr_d = mem_rdata;
               state_d = FINISH;
               req_d   = 1'b0;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign MDRdataOut = mdr_q;
   assign mem_addr   = mar_q;
   assign mem_wdata  = mdr_q;
   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Randomized scoreboard bench for mem_interface_unit: the stimulus side predicts each
// transaction's outcome; a negedge monitor checks it when mem_req falls.
module tb_mem_interface_unit;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clock = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] BusMuxOut = '0;
   logic          MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
   logic [DW-1:0] MDRdataOut, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          mem_req, mem_we, busy, done, err;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;

   mem_interface_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
      .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
      .MDRdataOut(MDRdataOut), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit            timeout;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] mdr;
      bit            err;
      int            cycles;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;

   // Reference model state and two RAM images: ram is what the responder serves,
   // ref_mem is what the model believes was written.
   logic [AW-1:0] mar_m = '0;
   logic [DW-1:0] mdr_m = '0;
   bit            err_m = 1'b0;
   logic [DW-1:0] ram[512];
   logic [DW-1:0] ref_mem[512];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: one verdict per request, taken on the cycle mem_req drops.
   int            cyc;
   logic [AW-1:0] a0;
   logic [DW-1:0] wd0;
   bit            we0, stable, prev_req = 1'b0;
   always @(negedge clock) begin
      if (mon_en) begin
         if (mem_req) begin
            if (!prev_req) begin
               cyc = 0; a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata; stable = 1'b1;
            end
            if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0 || busy !== 1'b1)
               stable = 1'b0;
            cyc++;
         end else if (prev_req) begin
            if (sb.size() == 0) begin
               chk("unexpected_txn", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("req_cycles", cyc, e.cycles);
               chk("mem_we", we0, e.we);
               chk("mem_addr", a0, e.addr);
               chk("mem_wdata", wd0, e.wdata);
               chk("stable_while_busy", stable, 1);
               chk("done_pulse", done, !e.timeout);
               chk("busy_after", busy, 0);
               chk("err_flag", err, e.err);
               chk("mdr_after", MDRdataOut, e.mdr);
            end
         end else if (done) begin
            chk("spurious_done", done, 0);
         end
      end
      prev_req = mem_req;
   end

   task automatic load(input bit ma, input bit md, input logic [DW-1:0] bus);
      if (ma) mar_m = bus[AW-1:0];
      if (md) mdr_m = bus;
      MARin = ma; MDRin = md; BusMuxOut = bus;
      @(posedge clock); #1;
      MARin = 0; MDRin = 0; BusMuxOut = $urandom;
   endtask

   // op: 0 read, 1 write, 2 both (read expected); lat >= TO means no ack at all.
   task automatic txn(input bit ma, input bit md, input logic [DW-1:0] bus,
                      input int op, input int lat);
      exp_t e;
      if (ma) mar_m = bus[AW-1:0];
      if (md) mdr_m = bus;
      e.we = (op == 1);
      e.addr = mar_m;
      e.wdata = mdr_m;
      e.timeout = (lat >= TO);
      e.cycles = e.timeout ? TO : lat + 1;
      if (e.timeout) err_m = 1'b1;
      else if (e.we) ref_mem[mar_m] = mdr_m;
      else mdr_m = ref_mem[mar_m];
      e.mdr = mdr_m;
      e.err = err_m;
      sb.push_back(e);

      MARin = ma; MDRin = md; BusMuxOut = bus;
      Read = (op != 1); Write = (op != 0);
      @(posedge clock); #1;
      MARin = 0; MDRin = 0; Read = 0; Write = 0;
      for (int w = 0; w < TO; w++) begin
         if (w == lat) begin
            mem_ack = 1'b1;
            mem_rdata = ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
         end else begin
            mem_rdata = $urandom;
         end
         BusMuxOut = $urandom;
         MARin = 1'($urandom); MDRin = 1'($urandom);
         Read = 1'($urandom); Write = 1'($urandom);
         @(posedge clock); #1;
         mem_ack = 1'b0;
         MARin = 0; MDRin = 0; Read = 0; Write = 0;
         if (w == lat) break;
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 512; i++) begin
         ram[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
         ref_mem[i] = ram[i];
      end
      repeat (2) @(posedge clock);
      #1 clear = 1'b1;
      @(posedge clock); #1;
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_mdr", MDRdataOut, 0);
      mon_en = 1'b1;

      load(1, 0, 32'h0000_01A5);
      chk("mar_load", mem_addr, 9'h1A5);
      load(1, 0, 32'hFFFF_FFFF);
      chk("mar_trunc", mem_addr, 9'h1FF);

      mem_ack = 1'b1;
      @(posedge clock); #1;
      mem_ack = 1'b0;
      chk("idle_ack_ignored", {busy, mem_req, done}, 0);

      load(0, 1, 32'hDEAD_BEEF);
      load(1, 0, 32'h0000_0010);
      txn(0, 0, '0, 1, 3);
      txn(0, 0, '0, 0, 0);
      chk("read_back", MDRdataOut, 32'hDEAD_BEEF);
      txn(0, 0, '0, 0, TO);
      txn(1, 0, 32'h0000_0123, 0, 1);
      txn(0, 0, '0, 2, 2);
      txn(1, 1, 32'h1357_9BDF, 1, TO - 1);

      for (int n = 0; n < 40; n++) begin
         int r, lat;
         r = $urandom_range(0, 9);
         if (r < 6) lat = $urandom_range(0, 4);
         else if (r < 8) lat = TO - 1;
         else lat = TO;
         if ($urandom_range(0, 3) == 0) load(1'($urandom), 1'($urandom), $urandom);
         txn(1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), lat);
      end

      // Asynchronous reset in the middle of a write
      @(negedge clock);
      mon_en = 1'b0;
      @(posedge clock); #1;
      Write = 1'b1;
      @(posedge clock); #1;
      Write = 1'b0;
      chk("wr_started", mem_req, 1);
      #2 clear = 1'b0;
      #1 chk("async_req_drop", mem_req, 0);
      chk("async_busy_drop", busy, 0);
      @(posedge clock); #1;
      clear = 1'b1;
      mar_m = '0; mdr_m = '0; err_m = 1'b0;
      sb.delete();
      @(posedge clock); #1;
      chk("post_rst_err", err, 0);
      chk("post_rst_addr", mem_addr, 0);
      @(negedge clock);
      mon_en = 1'b1;
      @(posedge clock); #1;
      txn(0, 0, '0, 0, 1);

      repeat (3) @(posedge clock);
      #1 chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_interface_unit.md
Name: mem_interface_unit

Overview:
- Memory-side consumer of the datapath bus. Holds MAR and MDR, sequences single-word reads and writes to an external synchronous RAM over a req/ack handshake, and supplies MDRdataOut back to the bus mux as the MDRout source.
- Driven by control-unit strobes (MARin, MDRin, Read, Write).
- Adds a wait-state tolerant FSM with a timeout watchdog.

Parameters:
ADDR_W, 9, MAR width; mem_addr = MAR.
DATA_W, 32, data width of bus, MDR and memory.
TIMEOUT, 15, maximum cycles to wait for mem_ack before abort (1..255).

Ports:
clock  in  1  rising-edge clock.
clear  in  1  asynchronous, active-low reset.
BusMuxOut  in  DATA_W  datapath bus value.
MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
MDRin  in  1  load MDR from BusMuxOut.
Read  in  1  start memory read at MAR (pulse).
Write  in  1  start memory write of MDR to MAR (pulse).
MDRdataOut  out  DATA_W  MDR contents to bus mux.
mem_addr  out  ADDR_W  RAM address (= MAR).
mem_wdata  out  DATA_W  RAM write data (= MDR).
mem_req  out  1  RAM request, held until ack.
mem_we  out  1  1 = write, valid with mem_req.
mem_rdata  in  DATA_W  RAM read data, valid with mem_ack.
mem_ack  in  1  RAM completion, one cycle.
busy  out  1  transaction in progress.
done  out  1  one-cycle pulse on successful completion.
err  out  1  sticky timeout flag.

Behaviour:
- Reset (clear=0, async): MAR=0, MDR=0, state=IDLE, counter=0, mem_req=0, mem_we=0, busy=0, done=0, err=0.
- All outputs are registered except mem_addr, mem_wdata and MDRdataOut, which are direct register views.
- States: IDLE, RD_WAIT, WR_WAIT, FINISH.
- IDLE:
  - MARin loads MAR at the edge.
  - MDRin loads MDR at the edge.
  - Read=1 → RD_WAIT: mem_req=1, mem_we=0, busy=1, counter=0.
  - Write=1 → WR_WAIT: mem_req=1, mem_we=1, busy=1, counter=0.
  - Read and Write both 1: Read wins; Write is dropped.
  - MARin together with Read/Write in the same cycle: MAR is loaded first, and the request uses the new address on the next cycle. MDRin with Write behaves the same way (new MDR is written).
- RD_WAIT: on mem_ack, MDR ← mem_rdata, mem_req=0, state → FINISH.
- WR_WAIT: on mem_ack, mem_req=0, mem_we=0, state → FINISH. MDR is unchanged.
- Timeout:
  - In RD_WAIT or WR_WAIT without ack, counter increments each cycle.
  - When counter reaches TIMEOUT-1 with no ack: err=1, mem_req=0, mem_we=0, state → IDLE, busy=0, done is not pulsed, MDR is unchanged.
  - Ack arriving in the same cycle as expiry counts as success.
- FINISH: done=1 for exactly this cycle, busy=0, state → IDLE. Latency from a Read pulse with zero-wait ack (ack the cycle after req rises) to done is 3 cycles.
- While busy (RD_WAIT, WR_WAIT, FINISH):
  - MARin, MDRin, Read and Write are ignored; no queuing.
  - mem_addr and mem_wdata stay stable.
- mem_ack while in IDLE or FINISH: ignored.
- err clears only on reset. A new transaction is still accepted when err=1.
- MAR load truncates the bus to the low ADDR_W bits; upper bits are discarded.
- Reset mid-transaction drops mem_req immediately (async) and aborts the transaction.

Test Plan:
- Reset/idle: clear=0 then release → all outputs 0. MARin with bus=0x0000_01A5 → mem_addr=0x1A5. Bus=0xFFFF_FFFF → mem_addr=0x1FF.
- Write: MDRin bus=0xDEAD_BEEF, MARin bus=0x010, Write pulse, ack after 3 wait cycles → mem_req/mem_we high for 4 cycles, mem_wdata=0xDEADBEEF, mem_addr=0x010, one done pulse, err=0.
- Read: MAR=0x010, Read pulse, ack next cycle with rdata=0x1234_5678 → MDRdataOut=0x12345678 in the FINISH cycle, done 3 cycles after Read, mem_we=0 throughout.
- Busy lockout: during RD_WAIT apply MARin bus=0x0FF, MDRin bus=0x0, and a Write pulse → MAR, MDR and mem_addr unchanged; no second transaction after done.
- Timeout: Read with ack never asserted → after TIMEOUT cycles req drops, err=1, done stays 0, MDR unchanged. A following Read with prompt ack completes normally and err stays 1.
- Collision and reset: Read=Write=1 → read performed (mem_we=0). Assert clear during WR_WAIT → mem_req falls without waiting for a clock edge, and state is IDLE after release.
